// File: rtl/ocr_pkg.sv
`default_nettype none
// ============================================================================
// ocr_pkg : shared word width, state encoding and popcount helper for OCR.
// Revision: 1.0
// ============================================================================
package ocr_pkg;

    localparam int OCR_WORD_W = 32;
    localparam int OCR_ONES_W = $clog2(OCR_WORD_W + 1);

    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        PACK     = 1'b1
    } ocr_state_e;

    function automatic logic [OCR_ONES_W-1:0] ocr_popcount(input logic [OCR_WORD_W-1:0] w);
        logic [OCR_ONES_W-1:0] c;
        c = '0;
        for (int i = 0; i < OCR_WORD_W; i++) begin
            c = c + OCR_ONES_W'(w[i]);
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ocr_word_popcount.sv
`default_nettype none
// ============================================================================
// ocr_word_popcount : combinational ink count of a packed pixel word.
// Revision: 1.0
// ============================================================================
module ocr_word_popcount
    import ocr_pkg::*;
#(
    parameter int W  = OCR_WORD_W,
    parameter int OW = $clog2(W + 1)
) (
    input  logic [W-1:0]  word,
    output logic [OW-1:0] ones
);

    generate
        if (W == OCR_WORD_W && OW == OCR_ONES_W) begin : g_pkg_width
            assign ones = ocr_popcount(word);
        end else begin : g_generic_width
            always_comb begin
                ones = '0;
                for (int i = 0; i < W; i++) begin
                    ones = ones + OW'(word[i]);
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/ocr_pixel_packer.sv
`default_nettype none
// ============================================================================
// ocr_pixel_packer : packs a raster pixel stream MSB-first into row words
//                    with eol/eof tags and ink count on a valid/ready port.
// Revision: 1.0
// ============================================================================
module ocr_pixel_packer
    import ocr_pkg::*;
#(
    parameter int WORD_W  = OCR_WORD_W,
    parameter int ROW_PIX = 40,
    parameter int ROWS    = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         pix_in,
    input  logic                         pix_valid,
    input  logic                         pix_sof,
    output logic                         pix_ready,
    output logic [WORD_W-1:0]            out_word,
    output logic [$clog2(WORD_W+1)-1:0]  out_ones,
    output logic                         out_eol,
    output logic                         out_eof,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         err_sof
);

    localparam int ONES_W = $clog2(WORD_W + 1);
    localparam int PW     = (WORD_W  > 1) ? $clog2(WORD_W)  : 1;
    localparam int CW     = (ROW_PIX > 1) ? $clog2(ROW_PIX) : 1;
    localparam int RW     = (ROWS    > 1) ? $clog2(ROWS)    : 1;

    localparam logic [PW-1:0] PIX_LAST = PW'(WORD_W - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(ROW_PIX - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    ocr_state_e          state_q, state_d;
    logic [WORD_W-1:0]   pack_q, pack_d;
    logic [PW-1:0]       pix_cnt_q, pix_cnt_d;
    logic [CW-1:0]       col_cnt_q, col_cnt_d;
    logic [RW-1:0]       row_cnt_q, row_cnt_d;
    logic                full_q, full_d;
    logic                eol_pend_q, eol_pend_d;
    logic                eof_pend_q, eof_pend_d;
    logic [WORD_W-1:0]   out_word_q, out_word_d;
    logic [ONES_W-1:0]   out_ones_q, out_ones_d;
    logic                out_eol_q, out_eol_d;
    logic                out_eof_q, out_eof_d;
    logic                out_valid_q, out_valid_d;
    logic                err_sof_q, err_sof_d;

    logic                out_free, move, accept, take;
    logic [PW-1:0]       eff_pix;
    logic [CW-1:0]       eff_col;
    logic [RW-1:0]       eff_row;
    logic                at_eol, at_eof, done;
    logic [ONES_W-1:0]   pad_ones;

    ocr_word_popcount #(.W(WORD_W), .OW(ONES_W)) u_popcount (
        .word (pack_q),
        .ones (pad_ones)
    );

    assign out_free  = !out_valid_q || out_ready;
    assign pix_ready = !RST && (!full_q || out_free);
    assign accept    = pix_valid && pix_ready;
    assign move      = full_q && out_free;

    // Any accepted SOF restarts the frame, so the counters it sees are zero.
    assign take    = accept && (pix_sof || state_q == PACK);
    assign eff_pix = (accept && pix_sof) ? '0 : pix_cnt_q;
    assign eff_col = (accept && pix_sof) ? '0 : col_cnt_q;
    assign eff_row = (accept && pix_sof) ? '0 : row_cnt_q;
    assign at_eol  = (eff_col == COL_LAST);
    assign at_eof  = at_eol && (eff_row == ROW_LAST);
    assign done    = (eff_pix == PIX_LAST) || at_eol;

    always_comb begin
        state_d     = state_q;
        pack_d      = pack_q;
        pix_cnt_d   = pix_cnt_q;
        col_cnt_d   = col_cnt_q;
        row_cnt_d   = row_cnt_q;
        full_d      = full_q;
        eol_pend_d  = eol_pend_q;
        eof_pend_d  = eof_pend_q;
        out_word_d  = out_word_q;
        out_ones_d  = out_ones_q;
        out_eol_d   = out_eol_q;
        out_eof_d   = out_eof_q;
        out_valid_d = out_valid_q;
        err_sof_d   = err_sof_q;

        if (move) begin
            out_word_d  = pack_q;
            out_ones_d  = pad_ones;
            out_eol_d   = eol_pend_q;
            out_eof_d   = eof_pend_q;
            out_valid_d = 1'b1;
            full_d      = 1'b0;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept && pix_sof && state_q == PACK) begin
            err_sof_d = 1'b1;
        end

        if (take) begin
            // Starting a fresh word zeroes it, which also discards any partial word.
            if (eff_pix == '0) begin
                pack_d = '0;
            end
            pack_d[PIX_LAST - eff_pix] = pix_in;
            state_d   = PACK;
            pix_cnt_d = eff_pix + 1'b1;
            col_cnt_d = eff_col + 1'b1;
            row_cnt_d = eff_row;
            if (done) begin
                full_d     = 1'b1;
                eol_pend_d = at_eol;
                eof_pend_d = at_eof;
                pix_cnt_d  = '0;
                if (at_eol) begin
                    col_cnt_d = '0;
                    row_cnt_d = eff_row + 1'b1;
                end
                if (at_eof) begin
                    row_cnt_d = '0;
                    state_d   = WAIT_SOF;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= WAIT_SOF;
            pack_q      <= '0;
            pix_cnt_q   <= '0;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            full_q      <= 1'b0;
            eol_pend_q  <= 1'b0;
            eof_pend_q  <= 1'b0;
            out_word_q  <= '0;
            out_ones_q  <= '0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_valid_q <= 1'b0;
            err_sof_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pack_q      <= pack_d;
            pix_cnt_q   <= pix_cnt_d;
            col_cnt_q   <= col_cnt_d;
            row_cnt_q   <= row_cnt_d;
            full_q      <= full_d;
            eol_pend_q  <= eol_pend_d;
            eof_pend_q  <= eof_pend_d;
            out_word_q  <= out_word_d;
            out_ones_q  <= out_ones_d;
            out_eol_q   <= out_eol_d;
            out_eof_q   <= out_eof_d;
            out_valid_q <= out_valid_d;
            err_sof_q   <= err_sof_d;
        end
    end

    assign out_word  = out_word_q;
    assign out_ones  = out_ones_q;
    assign out_eol   = out_eol_q;
    assign out_eof   = out_eof_q;
    assign out_valid = out_valid_q;
    assign err_sof   = err_sof_q;

endmodule
`default_nettype wire
